// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locking arbiter that shares one uart transmitter among NUM_REQ byte sources.
// Optional stall watchdog is built when UART_TX_ARB_WATCHDOG_EN is defined.
module uart_tx_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int IDX_W       = 2,
   parameter int WDOG_CYCLES = 65535
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [NUM_REQ-1:0]   req_last,
   input  logic [8*NUM_REQ-1:0] req_byte,
   output logic [NUM_REQ-1:0]   req_ack,
   output logic [NUM_REQ-1:0]   grant,
   output logic                 locked,
   output logic                 uart_transmit,
   output logic [7:0]           uart_tx_byte,
   input  logic                 uart_is_transmitting,
   output logic                 wdog_error
);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT_START = 2'd1,
      WAIT_DONE  = 2'd2
   } state_t;

   state_t           state_r;
   logic [IDX_W-1:0] ptr_r;
   logic [IDX_W-1:0] owner_r;
   logic [IDX_W-1:0] pick_idx_s;
   logic             pick_valid_s;
   logic             accept_s;
   logic             wdog_hit_s;

   if (NUM_REQ < 2 || NUM_REQ > 8 || IDX_W != $clog2(NUM_REQ) ||
       WDOG_CYCLES < 1 || WDOG_CYCLES > 65535) begin : g_bad_cfg
      $error("uart_tx_arbiter: unsupported NUM_REQ/IDX_W/WDOG_CYCLES combination");
   end

   // Candidate selection: only the owner while locked, otherwise first valid after the pointer
   always_comb begin
      logic [IDX_W-1:0] idx_v;
      logic             hit_v;
      idx_v        = '0;
      hit_v        = 1'b0;
      pick_valid_s = 1'b0;
      pick_idx_s   = '0;
      if (locked) begin
         pick_valid_s = req_valid[owner_r];
         pick_idx_s   = owner_r;
      end else begin
         for (int k = 1; k <= NUM_REQ; k++) begin
            idx_v        = IDX_W'((int'(ptr_r) + k) % NUM_REQ);
            hit_v        = !pick_valid_s && req_valid[idx_v];
            pick_idx_s   = hit_v ? idx_v : pick_idx_s;
            pick_valid_s = pick_valid_s || hit_v;
         end
      end
   end

   assign accept_s = (state_r == IDLE) && !uart_is_transmitting && pick_valid_s;

`ifdef UART_TX_ARB_WATCHDOG_EN
   logic [15:0] wdog_cnt_r;
   logic        wdog_wait_s;
   logic        state_chg_s;

   assign state_chg_s = accept_s ||
                        ((state_r == WAIT_START) && uart_is_transmitting) ||
                        ((state_r == WAIT_DONE) && !uart_is_transmitting);
   assign wdog_wait_s = (state_r != IDLE) || (locked && !req_valid[owner_r]);
   assign wdog_hit_s  = wdog_wait_s && !state_chg_s &&
                        (wdog_cnt_r == 16'(WDOG_CYCLES - 1));

   // Stall counter: runs only while waiting on the uart or on a silent lock owner
   always_ff @(posedge clk) begin
      if (!rst) begin
         wdog_cnt_r <= 16'd0;
      end else if (!wdog_wait_s || state_chg_s || wdog_hit_s) begin
         wdog_cnt_r <= 16'd0;
      end else begin
         wdog_cnt_r <= wdog_cnt_r + 16'd1;
      end
   end
`else
   assign wdog_hit_s = 1'b0;
`endif

   // Arbitration state machine; every output is registered here
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r       <= IDLE;
         ptr_r         <= IDX_W'(NUM_REQ - 1);
         owner_r       <= '0;
         locked        <= 1'b0;
         grant         <= '0;
         req_ack       <= '0;
         uart_transmit <= 1'b0;
         uart_tx_byte  <= 8'd0;
         wdog_error    <= 1'b0;
      end else begin
         req_ack       <= '0;
         uart_transmit <= 1'b0;
         wdog_error    <= 1'b0;
         if (wdog_hit_s) begin
            state_r    <= IDLE;
            locked     <= 1'b0;
            grant      <= '0;
            wdog_error <= 1'b1;
         end else begin
            case (state_r)
               IDLE: begin
                  if (accept_s) begin
                     uart_tx_byte  <= req_byte[{pick_idx_s, 3'b000} +: 8];
                     uart_transmit <= 1'b1;
                     req_ack       <= NUM_REQ'(1'b1) << pick_idx_s;
                     grant         <= NUM_REQ'(1'b1) << pick_idx_s;
                     ptr_r         <= pick_idx_s;
                     owner_r       <= pick_idx_s;
                     locked        <= ~req_last[pick_idx_s];
                     state_r       <= WAIT_START;
                  end
               end
               WAIT_START: begin
                  if (uart_is_transmitting) begin
                     state_r <= WAIT_DONE;
                  end
               end
               WAIT_DONE: begin
                  if (!uart_is_transmitting) begin
                     state_r <= IDLE;
                     // A locked owner keeps its grant across the idle gap between bytes
                     if (!locked) begin
                        grant <= '0;
                     end
                  end
               end
               default: begin
                  state_r <= IDLE;
               end
            endcase
         end
      end
   end

endmodule
